// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: UART transmit framing FSM (start bit, data via serializer, optional parity, stop bit)
// Ports: CLK rising-edge clock; RST asynchronous active-low reset;
//   P_DATA/Data_Valid word and strobe; PAR_EN/PAR_TYP parity enable and type (0 even, 1 odd);
//   Ser_Data/Ser_Done current bit and last-bit flag from the serializer;
//   Ser_En serializer shift enable; Busy frame in progress; TX_OUT serial line (idle high).
// Define UART_TX_PARITY_EN to build the PARITY state; without it PAR_EN/PAR_TYP are ignored.
module uart_tx_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             Data_Valid,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  input  logic             Ser_Data,
  input  logic             Ser_Done,
  output logic             Ser_En,
  output logic             Busy,
  output logic             TX_OUT
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  logic [2:0] state, state_nxt, data_exit;
  logic is_par, par_bit;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
  logic par_en_q, par_typ_q, par_x_q;
  // configuration and data parity are frozen at acceptance so mid-frame input changes are ignored
  always_ff @(posedge CLK or negedge RST)
    if (!RST) {par_en_q, par_typ_q, par_x_q} <= '0;
    else if (Data_Valid && !Busy) {par_en_q, par_typ_q, par_x_q} <= {PAR_EN, PAR_TYP, ^P_DATA};
  assign is_par = state == PARITY;
  assign par_bit = par_x_q ^ par_typ_q;
  assign data_exit = par_en_q ? PARITY : STOP;
`else
  logic unused_cfg;
  assign unused_cfg = ^{PAR_EN, PAR_TYP, P_DATA};
  assign is_par = 1'b0;
  assign par_bit = 1'b1;
  assign data_exit = STOP;
`endif
  // STOP and any unreachable encoding fall through to IDLE
  always_comb
    state_nxt = (state == IDLE)  ? (Data_Valid ? START : IDLE) :
                (state == START) ? DATA :
                (state == DATA)  ? (Ser_Done ? data_exit : DATA) :
                is_par           ? STOP : IDLE;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state <= IDLE;
      Busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      Busy  <= state_nxt != IDLE;
    end
  assign Ser_En = state == DATA;
  always_comb
    TX_OUT = (state == START) ? 1'b0 :
             (state == DATA)  ? Ser_Data :
             is_par           ? par_bit : 1'b1;
endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb_uart_tx_fsm: randomized self-checking bench for uart_tx_fsm against a frame-queue reference model
module tb_uart_tx_fsm;
  localparam int W = 8;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif
  logic CLK, RST, Data_Valid, PAR_EN, PAR_TYP, Ser_Data, Ser_Done, Ser_En, Busy, TX_OUT;
  logic [W-1:0] P_DATA;
  logic noise;
  logic [W-1:0] sh;
  logic [3:0] cnt;
  logic [1:0] q[$];
  logic [10:0] hist;
  int n_chk, n_pass;

  uart_tx_fsm #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .Ser_Data(Ser_Data), .Ser_Done(Ser_Done),
    .Ser_En(Ser_En), .Busy(Busy), .TX_OUT(TX_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // simple LSB-first serializer; Ser_Done carries random noise outside DATA
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      sh  <= '0;
      cnt <= '0;
    end else if (Data_Valid && !Busy) begin
      sh  <= P_DATA;
      cnt <= '0;
    end else if (Ser_En) begin
      sh  <= sh >> 1;
      cnt <= cnt + 4'd1;
    end
  assign Ser_Data = sh[0];
  assign Ser_Done = Ser_En ? (cnt == 4'(W - 1)) : noise;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // each queue entry is one line cycle: {ser_en, tx}
  task automatic push_frame(input logic [W-1:0] d, input logic pe, input logic pt);
    q.push_back(2'b00);
    for (int i = 0; i < W; i++) q.push_back({1'b1, d[i]});
    if (pe && PAR_BUILD) q.push_back({1'b0, (^d) ^ pt});
    q.push_back(2'b01);
  endtask

  task automatic tick();
    logic acc, pe, pt;
    logic [W-1:0] d;
    logic [1:0] e;
    acc = (q.size() == 0) && Data_Valid;
    d = P_DATA;
    pe = PAR_EN;
    pt = PAR_TYP;
    @(posedge CLK);
    if (q.size() != 0) void'(q.pop_front());
    else if (acc) push_frame(d, pe, pt);
    @(negedge CLK);
    e = (q.size() != 0) ? q[0] : 2'b01;
    chk("tx_out", TX_OUT, e[0]);
    chk("busy", Busy, q.size() != 0);
    chk("ser_en", Ser_En, e[1]);
    hist = {hist[9:0], TX_OUT};
    noise = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [W-1:0] d, input logic pe, input logic pt);
    P_DATA = d;
    PAR_EN = pe;
    PAR_TYP = pt;
    Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    hist = '0;
    noise = 1'b0;
    RST = 1'b0;
    Data_Valid = 1'b0;
    P_DATA = '0;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    #1;
    chk("rst_tx", TX_OUT, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_ser_en", Ser_En, 0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) tick();
    send(8'hA5, 1'b0, 1'b0);
    repeat (9) tick();
    chk("a5_frame", hist[9:0], 10'b0101001011);
    tick();
    chk("a5_idle_busy", Busy, 0);
    send(8'hA5, 1'b1, 1'b0);
    repeat (12) tick();
    send(8'hA5, 1'b1, 1'b1);
    repeat (12) tick();
    send(8'h01, 1'b1, 1'b0);
    repeat (11) begin
      PAR_TYP = ~PAR_TYP;
      P_DATA = 8'($urandom);
      PAR_EN = 1'($urandom_range(0, 1));
      tick();
    end
    Data_Valid = 1'b1;
    repeat (45) begin
      P_DATA = (q.size() == 0) ? 8'h3C : 8'($urandom);
      PAR_EN = 1'($urandom_range(0, 1));
      tick();
    end
    Data_Valid = 1'b0;
    repeat (12) tick();
    send(8'h5A, 1'b1, 1'b0);
    repeat (4) tick();
    RST = 1'b0;
    #1;
    chk("abort_tx", TX_OUT, 1);
    chk("abort_busy", Busy, 0);
    chk("abort_ser_en", Ser_En, 0);
    q.delete();
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    repeat (15) tick();
    repeat (500) begin
      Data_Valid = ($urandom_range(0, 3) == 0);
      P_DATA = 8'($urandom);
      PAR_EN = 1'($urandom_range(0, 1));
      PAR_TYP = 1'($urandom_range(0, 1));
      tick();
    end
    Data_Valid = 1'b0;
    repeat (12) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
